jk_mod_counter: RTL and testbench
=================================

// Module: jk_mod_counter
// PURPOSE
//  Synchronous up/down modulo-N counter built from a bank of JK flip-flop stages.
//  Per-bit J/K excitation is derived from the desired next count, so each stage
//  runs in set, reset, hold or toggle mode as needed.
//  This block is the consumer stage for the JK flip-flop: it drives J/K and reads
//  back q/q_bar. It is the first multi-bit sequential block built on that cell.
// PARAMETERS
//  WIDTH    4   counter width in bits (1..16)
//  MODULUS  10  count range 0..MODULUS-1; legal range 2..2**WIDTH
// PORTS
//  clk       in   1      rising-edge clock; the only clock
//  rst       in   1      synchronous, active-high reset
//  en        in   1      count enable; counts one step per cycle while high
//  up        in   1      direction: 1 = increment, 0 = decrement (sampled with en)
//  load      in   1      synchronous parallel load
//  load_val  in   WIDTH  value for load
//  count     out  WIDTH  registered count (stage q outputs)
//  count_bar out  WIDTH  bitwise complement of count (stage q_bar outputs)
//  wrap      out  1      registered 1-cycle pulse; high in the cycle count shows a wrapped value
// BEHAVIOUR
//  - Reset: while rst is high at a clk edge: count=0, count_bar={WIDTH{1}}, wrap=0.
//    rst overrides load and en. Mid-count reset clears on that same edge.
//  - Priority at each edge: rst > load > en > hold.
//  - Load: count <= load_val, or MODULUS-1 if load_val >= MODULUS (clamp).
//    wrap=0 on load. Takes effect in one cycle.
//  - Count up: if count==MODULUS-1, count <= 0 and wrap <= 1; else count+1 and wrap <= 0.
//  - Count down: if count==0, count <= MODULUS-1 and wrap <= 1; else count-1 and wrap <= 0.
//  - Hold (en=0, load=0): count unchanged, wrap <= 0.
//  - Latency: every command is visible on count/wrap one clk after the sampling edge.
//    count_bar is always ~count with no extra cycle.
//  - Excitation rule: for next value n and present q, per bit:
//    J_i = n_i & ~q_i, K_i = ~n_i & q_i. J=K=1 is never generated.
//    Hold produces J=K=0 on every stage.
//  - Direction change takes effect on the next enabled edge; there is no dead cycle.
//  - Out-of-range count (>= MODULUS) is reachable only via fault:
//    an up step maps it to 0 with wrap=1; a down step gives count-1.
//  - Arithmetic is WIDTH bits, unsigned; MODULUS-1 compare is a constant.
//  - No combinational path from any input to any output.
// STRUCTURE
//  - Sub-module jk_ff_stage (clk, rst, j, k, q, q_bar): one JK cell with
//    synchronous active-high reset to q=0. It is instantiated WIDTH times via generate.
//  - Shared package jk_pkg holds:
//    localparams for JK modes (JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TGL=2'b11),
//    and a function next_count(q, up, MODULUS).
//  - Top holds the next-value mux, the excitation logic and the wrap register only.
// TESTING
//  1. rst=1 for 3 cycles with en=1, load=1 -> count=0, count_bar=4'hF, wrap=0 throughout.
//  2. en=1, up=1 for 12 cycles from 0 (MODULUS=10) -> count 1..9,0,1,2.
//     wrap high only in the cycle count=0.
//  3. en=1, up=0 from 0 -> count=9 with wrap=1, then 8,7 with wrap=0.
//  4. load=1, load_val=6 with en=1 -> count=6, wrap=0 (load beats en).
//     load_val=13 -> count=9 (clamped).
//  5. Count to 7, then rst=1 for 1 cycle -> count=0 next edge.
//     en=0 for 5 cycles -> count and wrap are stable at 0.
//  6. Alternate up/down each cycle from 9 -> 0(wrap=1), 9(wrap=1), 0(wrap=1).
//     A bind assertion confirms no stage ever sees J=K=1.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared definitions for the JK-based modulo counter: stage excitation modes
// and the next-count rule used by the counter top.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    typedef struct packed {
        logic [15:0] value;
        logic        wrap;
    } step_t;

    // One up/down step modulo `modulus`; an out-of-range value stepping up folds to 0.
    function automatic step_t next_count(input logic [15:0] q,
                                         input logic        up,
                                         input logic [16:0] modulus);
        step_t       s;
        logic [16:0] max_v;
        max_v   = modulus - 17'd1;
        s.value = 16'd0;
        s.wrap  = 1'b0;
        if (up) begin
            if ({1'b0, q} >= max_v) begin
                s.value = 16'd0;
                s.wrap  = 1'b1;
            end else begin
                s.value = q + 16'd1;
            end
        end else begin
            if (q == 16'd0) begin
                s.value = max_v[15:0];
                s.wrap  = 1'b1;
            end else begin
                s.value = q - 16'd1;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/jk_exc_chk.sv
// Checker for the counter's JK excitation: no stage may be driven with J=K=1.
module jk_exc_chk #(
    parameter int WIDTH = 4
) (
    input logic             i_clk,
    input logic             i_rst,
    input logic [WIDTH-1:0] i_j,
    input logic [WIDTH-1:0] i_k
);

    a_no_jk_toggle: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_j & i_k) == {WIDTH{1'b0}});

endmodule

// File: rtl/jk_ff_stage.sv
// Single JK flip-flop cell with synchronous active-high reset to q=0.
module jk_ff_stage
    import jk_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_j,
    input  logic i_k,
    output logic o_q,
    output logic o_q_bar
);

    logic r_q;

    // JK state update: hold, reset, set or toggle selected by {j,k}.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= 1'b0;
        end else begin
            case ({i_j, i_k})
                JK_HOLD: r_q <= r_q;
                JK_RST:  r_q <= 1'b0;
                JK_SET:  r_q <= 1'b1;
                JK_TGL:  r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign o_q     = r_q;
    assign o_q_bar = ~r_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-N counter whose state lives in a bank of JK stages; the top
// picks the next value, derives per-bit J/K from it, and registers wrap.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_count_bar,
    output logic             o_wrap
);

    localparam logic [16:0]      MOD_L   = 17'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_bar;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_wrap_next;
    logic             w_unused;
    step_t            w_step;
    logic             r_wrap;

    assign w_step   = next_count(16'(w_q), i_up, MOD_L);
    assign w_unused = ^w_step.value;

    // Next-value selection: load (clamped) beats count, which beats hold.
    always_comb begin
        w_next      = w_q;
        w_wrap_next = 1'b0;
        if (i_load) begin
            if (17'(i_load_val) >= MOD_L) begin
                w_next = MAX_VAL;
            end else begin
                w_next = i_load_val;
            end
        end else if (i_en) begin
            w_next      = w_step.value[WIDTH-1:0];
            w_wrap_next = w_step.wrap;
        end else begin
            w_next      = w_q;
            w_wrap_next = 1'b0;
        end
    end

    // Set only bits that must rise, reset only bits that must fall.
    assign w_j = w_next & ~w_q;
    assign w_k = ~w_next & w_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
        jk_ff_stage u_stage (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_j     (w_j[gi]),
            .i_k     (w_k[gi]),
            .o_q     (w_q[gi]),
            .o_q_bar (w_q_bar[gi])
        );
    end

    // Wrap pulse register, aligned with the stage update.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_next;
        end
    end

    assign o_count     = w_q;
    assign o_count_bar = w_q_bar;
    assign o_wrap      = r_wrap;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter: directed scenarios then random traffic,
// checked against a modular-arithmetic reference model.
module tb_jk_mod_counter;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;

    logic             clk;
    logic             rst;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_bar;
    logic             wrap;

    typedef struct {
        logic [WIDTH-1:0] count;
        logic             wrap;
        int               id;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_err;
    int   m_count;
    bit   m_wrap;
    int   n_issued;

    bind jk_mod_counter jk_exc_chk #(.WIDTH(WIDTH)) u_exc_chk (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_j   (w_j),
        .i_k   (w_k)
    );

    jk_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_up        (up),
        .i_load      (load),
        .i_load_val  (load_val),
        .o_count     (count),
        .o_count_bar (count_bar),
        .o_wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input bit r, input bit e, input bit u, input bit l, input int lv);
        exp_t x;
        @(negedge clk);
        rst      = r;
        en       = e;
        up       = u;
        load     = l;
        load_val = WIDTH'(lv);
        if (r) begin
            m_count = 0;
            m_wrap  = 1'b0;
        end else if (l) begin
            m_count = (lv >= MODULUS) ? MODULUS - 1 : lv;
            m_wrap  = 1'b0;
        end else if (e && u) begin
            m_count = (m_count + 1) % MODULUS;
            m_wrap  = (m_count == 0);
        end else if (e) begin
            m_wrap  = (m_count == 0);
            m_count = (m_count + MODULUS - 1) % MODULUS;
        end else begin
            m_wrap  = 1'b0;
        end
        x.count  = WIDTH'(m_count);
        x.wrap   = m_wrap;
        x.id     = n_issued;
        n_issued = n_issued + 1;
        sb_q.push_back(x);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp = n_cmp + 1;
            if (count !== e.count) begin
                n_err = n_err + 1;
                $display("FAIL count step=%0d actual=%0d required=%0d", e.id, count, e.count);
            end
            n_cmp = n_cmp + 1;
            if (count_bar !== ~e.count) begin
                n_err = n_err + 1;
                $display("FAIL count_bar step=%0d actual=%h required=%h", e.id, count_bar, ~e.count);
            end
            n_cmp = n_cmp + 1;
            if (wrap !== e.wrap) begin
                n_err = n_err + 1;
                $display("FAIL wrap step=%0d actual=%0b required=%0b", e.id, wrap, e.wrap);
            end
        end
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        n_issued = 0;
        m_count  = 0;
        m_wrap   = 1'b0;
        rst      = 1'b0;
        en       = 1'b0;
        up       = 1'b0;
        load     = 1'b0;
        load_val = '0;

        // Reset dominates load and enable.
        repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b1, 7);
        // Up through the wrap.
        repeat (12) drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
        // Down from 0 wraps to MODULUS-1.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
        // Load beats enable, and clamps.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 6);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 13);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 15);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 10);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 0);
        // Count to 7, mid-count reset, then idle.
        repeat (7) drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
        repeat (5) drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
        // Alternating direction across the boundary.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 9);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0);

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, (1 << WIDTH) - 1)));
        end

        @(posedge clk);
        #2;
        n_cmp = n_cmp + 1;
        if (sb_q.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
